// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and defaults for the PC fetch sequencer
//
// Purpose: state encoding, default parameter values and a small helper
// shared by pc_fetch_sequencer and its PC adder.

package pc_seq_pkg;

  // Default datapath/address width in bits.
  localparam int PC_WORD_DEF = 16;
  // Default sequential PC increment in bytes.
  localparam int PC_DEF_OFFS_DEF = 2;
  // Default PC value loaded on reset.
  localparam logic [15:0] PC_RESET_VEC_DEF = 16'h0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_ACK = 3'd2,
    ISSUE    = 3'd3,
    FAULT    = 3'd4
  } pc_seq_state_t;

  // Instructions are halfword aligned, so an odd PC can never be fetched.
  function automatic logic pc_misaligned(input logic pc_lsb);
    return pc_lsb;
  endfunction

endpackage

// File: rtl/PC_offset_select.sv
// rtl/PC_offset_select.sv - shared PC adder with offset select
//
// Purpose: the single PC adder. Adds either the fixed sequential increment
// or a signed branch offset to the incoming PC, modulo 2^WORD.
//
// Ports:
//   sel_i     in   1     0: pc_i + DEF_OFFS, 1: pc_i + branch_i
//   branch_i  in   WORD  two's complement byte offset
//   pc_i      in   WORD  PC operand
//   pc_o      out  WORD  sum, wraps silently

module PC_offset_select #(
  parameter int WORD     = 16,
  parameter int DEF_OFFS = 2
) (
  input  logic            sel_i,
  input  logic [WORD-1:0] branch_i,
  input  logic [WORD-1:0] pc_i,
  output logic [WORD-1:0] pc_o
);

  logic [WORD-1:0] offs;

  // Two's complement addition: a negative branch offset needs no special
  // handling, and the carry out of the top bit is dropped on purpose.
  assign offs = sel_i ? branch_i : WORD'(DEF_OFFS);
  assign pc_o = pc_i + offs;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter owner and instruction fetch sequencer
//
// Purpose: holds the PC of the multi-cycle core, fetches one instruction at a
// time over a request/acknowledge memory port, presents it to the control
// unit and updates the PC (sequential, relative branch or absolute load)
// when the control unit reports completion. An odd PC raises a sticky fault.
//
// Ports:
//   clk_i          in   1     system clock, rising edge
//   rst_i          in   1     asynchronous active-high reset
//   run_i          in   1     fetch permitted while high
//   mem_req_o      out  1     instruction read request
//   mem_addr_o     out  WORD  fetch address (wire from pc_o)
//   mem_ack_i      in   1     memory returns data this cycle
//   mem_data_i     in   WORD  instruction word, valid with mem_ack_i
//   instr_o        out  WORD  latched instruction
//   instr_valid_o  out  1     instr_o valid for the control unit
//   done_i         in   1     current instruction finished (pulse)
//   br_take_i      in   1     with done_i: relative branch
//   br_offs_i      in   WORD  signed branch byte offset
//   ld_i           in   1     with done_i: absolute PC load (beats branch)
//   ld_addr_i      in   WORD  absolute target
//   pc_o           out  WORD  current PC
//   fault_o        out  1     sticky misaligned-PC fault

module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              WORD      = PC_WORD_DEF,
  parameter int              DEF_OFFS  = PC_DEF_OFFS_DEF,
  parameter logic [WORD-1:0] RESET_VEC = WORD'(PC_RESET_VEC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  output logic            mem_req_o,
  output logic [WORD-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [WORD-1:0] mem_data_i,
  output logic [WORD-1:0] instr_o,
  output logic            instr_valid_o,
  input  logic            done_i,
  input  logic            br_take_i,
  input  logic [WORD-1:0] br_offs_i,
  input  logic            ld_i,
  input  logic [WORD-1:0] ld_addr_i,
  output logic [WORD-1:0] pc_o,
  output logic            fault_o
);

  pc_seq_state_t   state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            fault_q, fault_d;

  logic            adder_sel;
  logic [WORD-1:0] adder_sum;

  // The adder only ever adds the branch offset while an instruction is
  // being issued; in every other state it produces the sequential step.
  assign adder_sel = (state_q == ISSUE);

  PC_offset_select #(
    .WORD     (WORD),
    .DEF_OFFS (DEF_OFFS)
  ) u_pc_adder (
    .sel_i    (adder_sel),
    .branch_i (br_offs_i),
    .pc_i     (pc_q),
    .pc_o     (adder_sum)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (pc_misaligned(pc_q[0])) begin
          state_d = FAULT;
        end else begin
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // run_i is deliberately not looked at here: a request, once made,
        // is always completed.
        if (mem_ack_i) begin
          instr_d = mem_data_i;
          pc_d    = adder_sum;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (done_i) begin
          if (ld_i) begin
            pc_d = ld_addr_i;
          end else if (br_take_i) begin
            // Relative to the PC that was already stepped past this
            // instruction.
            pc_d = adder_sum;
          end
          state_d = run_i ? FETCH : IDLE;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state. The
    // request is suppressed on entry to FETCH when the new PC is odd, which
    // keeps mem_req_o low during the cycle that detects the fault.
    req_d   = ((state_d == FETCH) || (state_d == WAIT_ACK)) &&
              !pc_misaligned(pc_d[0]);
    valid_d = (state_d == ISSUE);
    fault_d = fault_q || (state_d == FAULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - self-checking bench for pc_fetch_sequencer

module tb_pc_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        run_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [15:0] mem_data_i;
  logic [15:0] instr_o;
  logic        instr_valid_o;
  logic        done_i;
  logic        br_take_i;
  logic [15:0] br_offs_i;
  logic        ld_i;
  logic [15:0] ld_addr_i;
  logic [15:0] pc_o;
  logic        fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc_after;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [15:0] exp_pc;

  pc_fetch_sequencer #(
    .WORD      (16),
    .DEF_OFFS  (2),
    .RESET_VEC (16'h0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .run_i         (run_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .done_i        (done_i),
    .br_take_i     (br_take_i),
    .br_offs_i     (br_offs_i),
    .ld_i          (ld_i),
    .ld_addr_i     (ld_addr_i),
    .pc_o          (pc_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for a request, checks its address against the model PC, holds
  // ack off for ack_wait cycles, acks with data, then pops the scoreboard
  // once the instruction is presented.
  task automatic do_fetch(input logic [15:0] data, input int ack_wait);
    int        t;
    sb_entry_t e;
    t = 0;
    while (mem_req_o !== 1'b1 && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    chk("req_seen", {15'd0, mem_req_o}, 16'd1);
    if (mem_req_o !== 1'b1) return;
    chk("fetch_addr", mem_addr_o, exp_pc);
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk_i);
      chk("req_hold", {15'd0, mem_req_o}, 16'd1);
      chk("addr_hold", mem_addr_o, exp_pc);
    end
    mem_ack_i  = 1'b1;
    mem_data_i = data;
    sb.push_back('{instr: data, pc_after: exp_pc + 16'd2});
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    mem_data_i = 16'hDEAD;
    e = sb.pop_front();
    exp_pc = e.pc_after;
    chk("instr_valid", {15'd0, instr_valid_o}, 16'd1);
    chk("instr", instr_o, e.instr);
    chk("pc_after_ack", pc_o, e.pc_after);
  endtask

  task automatic do_issue(input logic ld, input logic [15:0] la,
                          input logic br, input logic [15:0] offs,
                          input logic run_after);
    run_i     = run_after;
    done_i    = 1'b1;
    ld_i      = ld;
    ld_addr_i = la;
    br_take_i = br;
    br_offs_i = offs;
    @(negedge clk_i);
    done_i    = 1'b0;
    ld_i      = 1'b0;
    br_take_i = 1'b0;
    if (ld) exp_pc = la;
    else if (br) exp_pc = exp_pc + offs;
    chk("pc_after_done", pc_o, exp_pc);
    chk("valid_drop", {15'd0, instr_valid_o}, 16'd0);
  endtask

  initial begin
    rst_i      = 1'b1;
    run_i      = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = 16'h0000;
    done_i     = 1'b0;
    br_take_i  = 1'b0;
    br_offs_i  = 16'h0000;
    ld_i       = 1'b0;
    ld_addr_i  = 16'h0000;
    exp_pc     = 16'h0000;

    @(negedge clk_i);
    chk("rst_pc", pc_o, 16'h0000);
    chk("rst_instr", instr_o, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid_o}, 16'd0);
    chk("rst_req", {15'd0, mem_req_o}, 16'd0);
    chk("rst_fault", {15'd0, fault_o}, 16'd0);

    // First fetch, ack on the third WAIT_ACK cycle.
    rst_i = 1'b0;
    run_i = 1'b1;
    do_fetch(16'hA5A5, 3);

    // Branch/load strobes without done_i must not move the PC.
    br_take_i = 1'b1;
    ld_i      = 1'b1;
    ld_addr_i = 16'h0F00;
    br_offs_i = 16'h0040;
    @(negedge clk_i);
    @(negedge clk_i);
    br_take_i = 1'b0;
    ld_i      = 1'b0;
    chk("no_done_pc", pc_o, exp_pc);
    chk("no_done_valid", {15'd0, instr_valid_o}, 16'd1);

    // Sequential run.
    do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    do_fetch(16'h1111, 1);
    do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    do_fetch(16'h2222, 2);
    chk("seq_pc", pc_o, 16'h0006);

    // Reach pc=0010 in ISSUE, then branch back by 8.
    do_issue(1'b1, 16'h000E, 1'b0, 16'h0000, 1'b1);
    do_fetch(16'h3333, 1);
    chk("pre_branch_pc", pc_o, 16'h0010);
    do_issue(1'b0, 16'h0000, 1'b1, 16'hFFF8, 1'b1);
    chk("branch_pc", pc_o, 16'h0008);
    do_fetch(16'h4444, 1);

    // Load beats branch.
    do_issue(1'b1, 16'h0100, 1'b1, 16'h0040, 1'b1);
    chk("ld_prio_pc", pc_o, 16'h0100);
    do_fetch(16'h5555, 1);

    // Wrap-around on the sequential step.
    do_issue(1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b1);
    do_fetch(16'h6666, 1);
    chk("wrap_pc", pc_o, 16'h0000);

    // Misaligned load -> fault, sticky.
    do_issue(1'b1, 16'h0103, 1'b0, 16'h0000, 1'b1);
    chk("fetch_odd_req", {15'd0, mem_req_o}, 16'd0);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      done_i    = 1'b1;
      ld_i      = 1'b1;
      ld_addr_i = 16'h0200;
      mem_ack_i = 1'b1;
      chk("fault_set", {15'd0, fault_o}, 16'd1);
      chk("fault_req", {15'd0, mem_req_o}, 16'd0);
      chk("fault_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("fault_pc", pc_o, 16'h0103);
      @(negedge clk_i);
    end
    done_i    = 1'b0;
    ld_i      = 1'b0;
    mem_ack_i = 1'b0;
    rst_i     = 1'b1;
    #1;
    chk("fault_rst_pc", pc_o, 16'h0000);
    chk("fault_rst_fault", {15'd0, fault_o}, 16'd0);
    @(negedge clk_i);

    // Async reset in the middle of WAIT_ACK.
    rst_i  = 1'b0;
    exp_pc = 16'h0000;
    do_fetch(16'h7777, 1);
    do_issue(1'b1, 16'h0200, 1'b0, 16'h0000, 1'b1);
    @(negedge clk_i);
    chk("wait_req", {15'd0, mem_req_o}, 16'd1);
    chk("wait_addr", mem_addr_o, 16'h0200);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_pc", pc_o, 16'h0000);
    chk("async_rst_req", {15'd0, mem_req_o}, 16'd0);
    chk("async_rst_instr", instr_o, 16'h0000);
    chk("async_rst_valid", {15'd0, instr_valid_o}, 16'd0);
    @(negedge clk_i);
    rst_i      = 1'b0;
    run_i      = 1'b0;
    exp_pc     = 16'h0000;
    mem_ack_i  = 1'b1;
    mem_data_i = 16'hBEEF;
    @(negedge clk_i);
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    chk("late_ack_instr", instr_o, 16'h0000);
    chk("late_ack_valid", {15'd0, instr_valid_o}, 16'd0);
    chk("late_ack_req", {15'd0, mem_req_o}, 16'd0);
    chk("late_ack_pc", pc_o, 16'h0000);

    // run_i low after done_i -> IDLE, no further request.
    run_i = 1'b1;
    do_fetch(16'h1234, 1);
    do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("idle_req", {15'd0, mem_req_o}, 16'd0);
    end
    chk("idle_pc", pc_o, 16'h0002);
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
